rf_write_arbiter: RTL and testbench

Shares the single write port of the 32×32 register bank between several writeback requesters, for example the ALU result path and the load-data path. Each requester uses a valid/ready handshake. A round-robin arbiter grants one requester per cycle and drives a registered write command (`rf_write`, `rf_dr`, `rf_wrData`) straight into the register bank. An optional scoreboard tracks destination registers with writes still outstanding, so decode can stall on read-after-write hazards.

---
 rtl/kgp_rf_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/rf_write_arbiter.sv | 125 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_rf_pkg.sv
// Shared register-file constants and types for the writeback path.
package kgp_rf_pkg;

  localparam int unsigned RF_AW       = 5;
  localparam int unsigned RF_DW       = 32;
  localparam int unsigned RF_NREGS    = 1 << RF_AW;
  localparam logic [RF_AW-1:0] RF_ZERO_REG = '0;

  // Upper bound on writeback requesters sharing one bank write port.
  localparam int unsigned RF_MAX_NREQ = 4;

  // One writeback request as seen by the bank.
  typedef struct packed {
    logic [RF_AW-1:0] dr;
    logic [RF_DW-1:0] data;
  } wb_req_t;

  // Round-robin successor of index idx among n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at i_ptr and wraps modulo NREQ.
// The first valid index wins. Reusable for any port-sharing arbitration.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

  logic [PW:0] w_sum;
  logic [PW:0] w_cand;

  // Walk offsets 0..NREQ-1 from the pointer and latch the first valid candidate.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_sum  = {1'b0, i_ptr} + (PW+1)'(k);
      w_cand = (w_sum >= NREQ_W) ? (w_sum - NREQ_W) : w_sum;
      if (!o_any && i_valid[w_cand[PW-1:0]]) begin
        o_any                      = 1'b1;
        o_grant[w_cand[PW-1:0]]    = 1'b1;
        o_idx                      = w_cand[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register bank's single write port between NREQ writeback requesters.
// Round-robin grant, registered write command, optional destination scoreboard.
// Build option: define RF_SCOREBOARD_EN to compile in the busy-bit scoreboard.
module rf_write_arbiter
  import kgp_rf_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = RF_AW,
  parameter int unsigned DW   = RF_DW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_dr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               rf_write,
  output logic [AW-1:0]      rf_dr,
  output logic [DW-1:0]      rf_wrData,
  input  logic               sb_set,
  input  logic [AW-1:0]      sb_set_dr,
  input  logic [AW-1:0]      sb_sr1,
  input  logic [AW-1:0]      sb_sr2,
  output logic               sb_busy1,
  output logic               sb_busy2
);

  localparam int unsigned PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW-1:0] ZERO_DR = AW'(RF_ZERO_REG);

  logic [PW-1:0]   r_ptr;
  logic            r_rf_write;
  logic [AW-1:0]   r_rf_dr;
  logic [DW-1:0]   r_rf_data;

  logic [NREQ-1:0] w_valid;
  logic [NREQ-1:0] w_grant;
  logic [PW-1:0]   w_idx;
  logic            w_xfer;
  logic [AW-1:0]   w_win_dr;
  logic [DW-1:0]   w_win_data;
  logic [PW-1:0]   w_ptr_next;

  // Nothing is granted while reset is held, so no request is consumed during reset.
  assign w_valid = reset ? '0 : req_valid;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .i_valid (w_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_xfer)
  );

  assign req_ready  = w_grant;
  assign w_win_dr   = req_dr[w_idx*AW +: AW];
  assign w_win_data = req_data[w_idx*DW +: DW];
  assign w_ptr_next = PW'(rr_next(32'(w_idx), NREQ));

  // Round-robin pointer: moves past the winner after each transfer, holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= w_ptr_next;
    end
  end

  // Output command register; r0 writes complete the handshake but never enable the bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rf_write <= 1'b0;
      r_rf_dr    <= '0;
      r_rf_data  <= '0;
    end else if (w_xfer) begin
      r_rf_write <= (w_win_dr != ZERO_DR);
      r_rf_dr    <= w_win_dr;
      r_rf_data  <= w_win_data;
    end else begin
      r_rf_write <= 1'b0;
    end
  end

  assign rf_write  = r_rf_write;
  assign rf_dr     = r_rf_dr;
  assign rf_wrData = r_rf_data;

`ifdef RF_SCOREBOARD_EN
  localparam int unsigned NREGS = 1 << AW;

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_d;

  // Busy bit drops on the edge the bank commits the write; a same-edge allocation wins.
  always_comb begin
    w_busy_d = r_busy;
    if (r_rf_write) begin
      w_busy_d[r_rf_dr] = 1'b0;
    end
    if (sb_set && (sb_set_dr != ZERO_DR)) begin
      w_busy_d[sb_set_dr] = 1'b1;
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_d;
    end
  end

  assign sb_busy1 = (sb_sr1 != ZERO_DR) && r_busy[sb_sr1];
  assign sb_busy2 = (sb_sr2 != ZERO_DR) && r_busy[sb_sr2];
`else
  logic w_sb_unused;
  assign w_sb_unused = ^{sb_set, sb_set_dr, sb_sr1, sb_sr2};
  assign sb_busy1    = 1'b0;
  assign sb_busy2    = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter against a queue/array-level reference model.
module tb_rf_write_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*AW-1:0] req_dr = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]    req_ready;
  logic               rf_write;
  logic [AW-1:0]      rf_dr;
  logic [DW-1:0]      rf_wrData;
  logic               sb_set = 1'b0;
  logic [AW-1:0]      sb_set_dr = '0;
  logic [AW-1:0]      sb_sr1 = '0;
  logic [AW-1:0]      sb_sr2 = '0;
  logic               sb_busy1;
  logic               sb_busy2;

  always #5 clk = ~clk;

  rf_write_arbiter #(
    .NREQ (NREQ),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_dr    (req_dr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_write  (rf_write),
    .rf_dr     (rf_dr),
    .rf_wrData (rf_wrData),
    .sb_set    (sb_set),
    .sb_set_dr (sb_set_dr),
    .sb_sr1    (sb_sr1),
    .sb_sr2    (sb_sr2),
    .sb_busy1  (sb_busy1),
    .sb_busy2  (sb_busy2)
  );

  int n_run  = 0;
  int n_fail = 0;

  // Requester-side state: one pending write per requester.
  bit          p_valid [NREQ];
  logic [4:0]  p_dr    [NREQ];
  logic [31:0] p_data  [NREQ];

  // Reference model state.
  int          m_ptr;
  bit          m_write;
  logic [4:0]  m_dr;
  logic [31:0] m_data;
  bit          m_busy [32];
  logic [31:0] bank   [32];

  // Expected grant: scan from the pointer, wrapping, first pending requester wins.
  function automatic logic [NREQ-1:0] ref_grant();
    logic [NREQ-1:0] g;
    g = '0;
    if (!reset) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g == '0 && p_valid[(m_ptr + k) % NREQ]) g[(m_ptr + k) % NREQ] = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic exp_busy(input logic [4:0] sr);
`ifdef RF_SCOREBOARD_EN
    return (sr != 5'd0) && m_busy[sr];
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]           = p_valid[i];
      req_dr[i*AW +: AW]     = p_dr[i];
      req_data[i*DW +: DW]   = p_data[i];
    end
    #1;
  endtask

  // Advance model and DUT across one rising edge; returns at the following falling edge.
  task automatic clock_edge();
    logic [NREQ-1:0] g;
    g = ref_grant();
    if (rf_write === 1'b1) bank[rf_dr] = rf_wrData;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i] === 1'b1) p_valid[i] = 1'b0;
    end
    if (reset) begin
      m_write = 1'b0;
      m_dr    = '0;
      m_data  = '0;
      m_ptr   = 0;
      for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
    end else begin
      if (m_write) m_busy[m_dr] = 1'b0;
      if (sb_set && sb_set_dr != 5'd0) m_busy[sb_set_dr] = 1'b1;
      m_write = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (g[i]) begin
          m_write = (p_dr[i] != 5'd0);
          m_dr    = p_dr[i];
          m_data  = p_data[i];
          m_ptr   = (i + 1) % NREQ;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    p_valid[0] = 1'b1; p_dr[0] = 5'd3; p_data[0] = $urandom;
    p_valid[1] = 1'b1; p_dr[1] = 5'd7; p_data[1] = $urandom;
    sb_sr1 = 5'd3; sb_sr2 = 5'd7;
    drive();
    clock_edge();
    drive();
    clock_edge();
    drive();
    n_run++; if (req_ready !== 2'b00) begin n_fail++;
      $display("FAIL reset_ready: got %b want 00", req_ready); end
    n_run++; if (rf_write !== 1'b0) begin n_fail++;
      $display("FAIL reset_rf_write: got %b want 0", rf_write); end
    n_run++; if (rf_dr !== 5'd0 || rf_wrData !== 32'd0) begin n_fail++;
      $display("FAIL reset_rf_cmd: got dr=%0d data=%h want 0/0", rf_dr, rf_wrData); end
    n_run++; if (sb_busy1 !== 1'b0 || sb_busy2 !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy: got %b%b want 00", sb_busy1, sb_busy2); end
    reset = 1'b0;
    drive();
    n_run++; if (req_ready !== 2'b01) begin n_fail++;
      $display("FAIL reset_first_grant: got %b want 01", req_ready); end
    clock_edge();
    drive();
    n_run++; if (rf_write !== 1'b1 || rf_dr !== 5'd3) begin n_fail++;
      $display("FAIL reset_first_write: got wr=%b dr=%0d want 1/3", rf_write, rf_dr); end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] prev;
    prev = 2'b01;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!p_valid[i]) begin
          p_valid[i] = 1'b1; p_dr[i] = (i == 0) ? 5'd3 : 5'd7; p_data[i] = $urandom;
        end
      end
      drive();
      n_run++; if (req_ready !== ~prev) begin n_fail++;
        $display("FAIL rr_alternate: got %b want %b", req_ready, ~prev); end
      n_run++; if (rf_write !== 1'b1 || rf_dr !== m_dr || rf_wrData !== m_data) begin n_fail++;
        $display("FAIL rr_write: got wr=%b dr=%0d data=%h want 1/%0d/%h",
                 rf_write, rf_dr, rf_wrData, m_dr, m_data); end
      prev = ~prev;
      clock_edge();
    end
  endtask

  task automatic test_r0_write();
    p_valid[0] = 1'b0; p_valid[1] = 1'b0;
    drive();
    clock_edge();
    p_valid[1] = 1'b1; p_dr[1] = 5'd0; p_data[1] = 32'hDEADBEEF;
    drive();
    n_run++; if (req_ready !== 2'b10) begin n_fail++;
      $display("FAIL r0_ready: got %b want 10", req_ready); end
    clock_edge();
    drive();
    n_run++; if (rf_write !== 1'b0 || rf_wrData !== 32'hDEADBEEF || rf_dr !== 5'd0) begin
      n_fail++;
      $display("FAIL r0_cmd: got wr=%b dr=%0d data=%h want 0/0/deadbeef",
               rf_write, rf_dr, rf_wrData); end
    clock_edge();
    drive();
    n_run++; if (bank[0] !== 32'd0) begin n_fail++;
      $display("FAIL r0_bank: got %h want 0", bank[0]); end
  endtask

  task automatic test_held();
    logic [31:0] d0, d1;
    d0 = $urandom; d1 = $urandom;
    p_valid[1] = 1'b1; p_dr[1] = 5'd11; p_data[1] = $urandom;
    drive();
    clock_edge();
    p_valid[0] = 1'b1; p_dr[0] = 5'd9;  p_data[0] = d0;
    p_valid[1] = 1'b1; p_dr[1] = 5'd10; p_data[1] = d1;
    drive();
    n_run++; if (req_ready !== 2'b01) begin n_fail++;
      $display("FAIL held_first: got %b want 01", req_ready); end
    clock_edge();
    drive();
    n_run++; if (req_ready !== 2'b10 || rf_dr !== 5'd9 || rf_wrData !== d0) begin n_fail++;
      $display("FAIL held_second: got rdy=%b dr=%0d data=%h want 10/9/%h",
               req_ready, rf_dr, rf_wrData, d0); end
    clock_edge();
    drive();
    n_run++; if (req_ready !== 2'b00 || rf_write !== 1'b1 || rf_dr !== 5'd10 ||
                 rf_wrData !== d1) begin n_fail++;
      $display("FAIL held_write: got rdy=%b wr=%b dr=%0d data=%h want 00/1/10/%h",
               req_ready, rf_write, rf_dr, rf_wrData, d1); end
    clock_edge();
    drive();
    n_run++; if (rf_write !== 1'b0) begin n_fail++;
      $display("FAIL held_no_dup: got wr=%b want 0", rf_write); end
  endtask

  task automatic test_scoreboard();
    logic want;
`ifdef RF_SCOREBOARD_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    sb_set = 1'b1; sb_set_dr = 5'd5; sb_sr1 = 5'd5; sb_sr2 = 5'd0;
    drive();
    clock_edge();
    sb_set = 1'b0;
    drive();
    n_run++; if (sb_busy1 !== want || sb_busy2 !== 1'b0) begin n_fail++;
      $display("FAIL sb_set: got %b%b want %b0", sb_busy1, sb_busy2, want); end
    p_valid[0] = 1'b1; p_dr[0] = 5'd5; p_data[0] = $urandom;
    drive();
    n_run++; if (sb_busy1 !== want) begin n_fail++;
      $display("FAIL sb_pending: got %b want %b", sb_busy1, want); end
    clock_edge();
    drive();
    clock_edge();
    drive();
    n_run++; if (sb_busy1 !== 1'b0) begin n_fail++;
      $display("FAIL sb_clear: got %b want 0", sb_busy1); end
    // Re-allocate r5 and write it again, allocating once more as the write commits.
    sb_set = 1'b1; sb_set_dr = 5'd5;
    drive();
    clock_edge();
    sb_set = 1'b0;
    p_valid[0] = 1'b1; p_dr[0] = 5'd5; p_data[0] = $urandom;
    drive();
    clock_edge();
    sb_set = 1'b1; sb_set_dr = 5'd5;
    drive();
    clock_edge();
    sb_set = 1'b0;
    drive();
    n_run++; if (sb_busy1 !== want) begin n_fail++;
      $display("FAIL sb_set_wins: got %b want %b", sb_busy1, want); end
    sb_set = 1'b1; sb_set_dr = 5'd0;
    drive();
    clock_edge();
    sb_set = 1'b0;
    drive();
    n_run++; if (sb_busy2 !== 1'b0) begin n_fail++;
      $display("FAIL sb_r0: got %b want 0", sb_busy2); end
  endtask

  task automatic test_mid_reset();
    p_valid[0] = 1'b1; p_dr[0] = 5'd3; p_data[0] = $urandom;
    p_valid[1] = 1'b1; p_dr[1] = 5'd7; p_data[1] = $urandom;
    drive();
    clock_edge();
    drive();
    n_run++; if (rf_write !== 1'b1) begin n_fail++;
      $display("FAIL midrst_pre: got wr=%b want 1", rf_write); end
    reset = 1'b1;
    drive();
    n_run++; if (req_ready !== 2'b00) begin n_fail++;
      $display("FAIL midrst_ready: got %b want 00", req_ready); end
    clock_edge();
    drive();
    n_run++; if (rf_write !== 1'b0 || rf_dr !== 5'd0 || sb_busy1 !== 1'b0) begin n_fail++;
      $display("FAIL midrst_cmd: got wr=%b dr=%0d busy=%b want 0/0/0",
               rf_write, rf_dr, sb_busy1); end
    reset = 1'b0;
    drive();
    n_run++; if (req_ready !== 2'b01) begin n_fail++;
      $display("FAIL midrst_ptr: got %b want 01", req_ready); end
    clock_edge();
  endtask

  task automatic test_random();
    int waited [NREQ];
    logic [NREQ-1:0] g;
    for (int i = 0; i < NREQ; i++) waited[i] = 0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!p_valid[i] && $urandom_range(0, 3) != 0) begin
          p_valid[i] = 1'b1;
          p_dr[i]    = 5'($urandom_range(0, 31));
          p_data[i]  = $urandom;
        end
      end
      sb_set    = ($urandom_range(0, 3) == 0);
      sb_set_dr = 5'($urandom_range(0, 31));
      sb_sr1    = 5'($urandom_range(0, 31));
      sb_sr2    = (c % 2 == 0) ? m_dr : 5'($urandom_range(0, 31));
      drive();
      g = ref_grant();
      n_run++; if (req_ready !== g) begin n_fail++;
        $display("FAIL rand_ready c=%0d: got %b want %b", c, req_ready, g); end
      n_run++; if (rf_write !== m_write || rf_dr !== m_dr || rf_wrData !== m_data) begin
        n_fail++;
        $display("FAIL rand_cmd c=%0d: got %b/%0d/%h want %b/%0d/%h", c,
                 rf_write, rf_dr, rf_wrData, m_write, m_dr, m_data); end
      n_run++; if (sb_busy1 !== exp_busy(sb_sr1) || sb_busy2 !== exp_busy(sb_sr2)) begin
        n_fail++;
        $display("FAIL rand_busy c=%0d: got %b%b want %b%b", c, sb_busy1, sb_busy2,
                 exp_busy(sb_sr1), exp_busy(sb_sr2)); end
      for (int i = 0; i < NREQ; i++) begin
        if (p_valid[i] && !g[i] && g != '0) waited[i]++;
        if (g[i]) waited[i] = 0;
        n_run++; if (waited[i] > NREQ - 1) begin n_fail++;
          $display("FAIL rand_fair c=%0d req=%0d: got %0d waits want <=%0d", c, i,
                   waited[i], NREQ - 1); end
      end
      clock_edge();
    end
    sb_set = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      bank[r]   = 32'd0;
      m_busy[r] = 1'b0;
    end
    for (int i = 0; i < NREQ; i++) begin
      p_valid[i] = 1'b0; p_dr[i] = '0; p_data[i] = '0;
    end
    m_ptr = 0; m_write = 1'b0; m_dr = '0; m_data = '0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_r0_write();
    test_held();
    test_scoreboard();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
